// File: rtl/pipe_ctrl_unit.sv
// Pipelined control/hazard unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall, ID branch flush, EX forwarding, data-memory freeze. Macro CTRL_BNE_EN adds bne.
module pipe_ctrl_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned OP_W   = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [OP_W-1:0]   Op_i,
    input  logic [2:0]        Funct3_i,
    input  logic [REG_AW-1:0] RS1addr_i,
    input  logic [REG_AW-1:0] RS2addr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic              RegEqual_i,
    input  logic              MemStall_i,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o,
    output logic              flush_o,
    output logic              Branch_o,
    output logic [1:0]        ALUOp_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ForwardA_o,
    output logic [1:0]        ForwardB_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic [REG_AW-1:0] WBRDaddr_o
);

    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned FWD_W   = 2;

    localparam logic [OP_W-1:0] OP_RTYPE  = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        ctrl_t             ctrl;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } idex_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rd;
    } memwb_t;

    ctrl_t  dec;
    logic   branch;
    logic   br_cond;
    logic   load_use;
    logic   hazard;
    idex_t  idex;
    exmem_t exmem;
    memwb_t memwb;

    // ID-stage decode; unknown opcodes (and unsupported branch funct3) fall out as NOP
    always_comb begin
        dec     = '0;
        branch  = 1'b0;
        br_cond = 1'b0;
        case (Op_i)
            OP_RTYPE: begin
                dec.alu_op    = 2'b10;
                dec.reg_write = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BRANCH: begin
`ifdef CTRL_BNE_EN
                case (Funct3_i)
                    3'b000: begin
                        dec.alu_op = 2'b01;
                        branch     = 1'b1;
                        br_cond    = RegEqual_i;
                    end
                    3'b001: begin
                        dec.alu_op = 2'b01;
                        branch     = 1'b1;
                        br_cond    = !RegEqual_i;
                    end
                    default: ;
                endcase
`else
                dec.alu_op = 2'b01;
                branch     = 1'b1;
                br_cond    = RegEqual_i;
`endif
            end
            default: ;
        endcase
    end

`ifndef CTRL_BNE_EN
    logic unused_funct3;
    assign unused_funct3 = ^Funct3_i;
`endif

    assign load_use = idex.ctrl.mem_read && (idex.rd != '0)
                      && ((idex.rd == RS1addr_i) || (idex.rd == RS2addr_i));
    assign hazard   = !MemStall_i && load_use;

    // Stall outranks hazard, hazard outranks flush; reset holds the front end enabled
    assign PCWrite_o   = !rst_i || (!MemStall_i && !hazard);
    assign IFIDWrite_o = !rst_i || (!MemStall_i && !hazard);
    assign flush_o     = branch && br_cond && !MemStall_i && !hazard;
    assign Branch_o    = branch;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else if (!MemStall_i) begin
            if (hazard) begin
                idex <= '0;
            end else begin
                idex.ctrl <= dec;
                idex.rd   <= RDaddr_i;
                idex.rs1  <= RS1addr_i;
                idex.rs2  <= RS2addr_i;
            end
            exmem.mem_read   <= idex.ctrl.mem_read;
            exmem.mem_write  <= idex.ctrl.mem_write;
            exmem.reg_write  <= idex.ctrl.reg_write;
            exmem.mem_to_reg <= idex.ctrl.mem_to_reg;
            exmem.rd         <= idex.rd;
            memwb.reg_write  <= exmem.reg_write;
            memwb.mem_to_reg <= exmem.mem_to_reg;
            memwb.rd         <= exmem.rd;
        end
    end

    // EX operand bypass: the younger producer in EX/MEM wins over MEM/WB
    always_comb begin
        ForwardA_o = FWD_W'(2'b00);
        ForwardB_o = FWD_W'(2'b00);
        if (exmem.reg_write && (exmem.rd != '0) && (exmem.rd == idex.rs1)) begin
            ForwardA_o = 2'b10;
        end else if (memwb.reg_write && (memwb.rd != '0) && (memwb.rd == idex.rs1)) begin
            ForwardA_o = 2'b01;
        end
        if (exmem.reg_write && (exmem.rd != '0) && (exmem.rd == idex.rs2)) begin
            ForwardB_o = 2'b10;
        end else if (memwb.reg_write && (memwb.rd != '0) && (memwb.rd == idex.rs2)) begin
            ForwardB_o = 2'b01;
        end
    end

    assign ALUOp_o    = idex.ctrl.alu_op;
    assign ALUSrc_o   = idex.ctrl.alu_src;
    assign MemRead_o  = exmem.mem_read;
    assign MemWrite_o = exmem.mem_write;
    assign RegWrite_o = memwb.reg_write;
    assign MemToReg_o = memwb.mem_to_reg;
    assign WBRDaddr_o = memwb.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: an instruction-level pipeline model predicts every output
// each cycle; a negedge monitor pops the predictions and compares.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [6:0] Op_i = '0;
    logic [2:0] Funct3_i = '0;
    logic [4:0] RS1addr_i = '0, RS2addr_i = '0, RDaddr_i = '0;
    logic       RegEqual_i = 1'b0, MemStall_i = 1'b0;
    logic       PCWrite_o, IFIDWrite_o, flush_o, Branch_o, ALUSrc_o;
    logic [1:0] ALUOp_o, ForwardA_o, ForwardB_o;
    logic       MemRead_o, MemWrite_o, RegWrite_o, MemToReg_o;
    logic [4:0] WBRDaddr_o;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(5), .OP_W(7)) dut (
        .clk_i(clk), .rst_i(rst_i), .Op_i(Op_i), .Funct3_i(Funct3_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .RegEqual_i(RegEqual_i), .MemStall_i(MemStall_i),
        .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .flush_o(flush_o),
        .Branch_o(Branch_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
        .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o), .WBRDaddr_o(WBRDaddr_o)
    );

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } instr_t;

    typedef struct {
        logic [1:0] alu;
        logic       src, mr, mw, rw, m2r, br;
    } ctl_t;

    typedef struct {
        logic       pcw, ifw, fl, br, src, mr, mw, rw, m2r;
        logic [1:0] alu, fa, fb;
        logic [4:0] wbrd;
    } exp_t;

    exp_t   sb[$];
    instr_t ex_s = '0, mem_s = '0, wb_s = '0;
    instr_t nx_ex = '0, nx_mem = '0, nx_wb = '0;
    int     checks = 0;
    int     errors = 0;

    function automatic logic is_branch(instr_t i);
`ifdef CTRL_BNE_EN
        return i.op == OP_BR && (i.f3 == 3'd0 || i.f3 == 3'd1);
`else
        return i.op == OP_BR;
`endif
    endfunction

    function automatic ctl_t decode(instr_t i);
        ctl_t c = '{alu: 2'b00, src: 0, mr: 0, mw: 0, rw: 0, m2r: 0, br: 0};
        if (i.op == OP_R)  begin c.alu = 2'b10; c.rw = 1; end
        if (i.op == OP_I)  begin c.src = 1; c.rw = 1; end
        if (i.op == OP_LW) begin c.src = 1; c.mr = 1; c.rw = 1; c.m2r = 1; end
        if (i.op == OP_SW) begin c.src = 1; c.mw = 1; end
        if (is_branch(i))  begin c.alu = 2'b01; c.br = 1; end
        return c;
    endfunction

    function automatic logic cond_met(instr_t i, logic eq);
`ifdef CTRL_BNE_EN
        return (i.f3 == 3'd1) ? !eq : eq;
`else
        return eq;
`endif
    endfunction

    function automatic logic [1:0] fwd(logic [4:0] rs);
        if (decode(mem_s).rw && mem_s.rd != 0 && mem_s.rd == rs) return 2'b10;
        if (decode(wb_s).rw && wb_s.rd != 0 && wb_s.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step(input logic rst, input logic stall, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic eq);
        instr_t id;
        exp_t   e;
        logic   haz;
        @(posedge clk);
        #1;
        ex_s = nx_ex; mem_s = nx_mem; wb_s = nx_wb;
        rst_i = rst; MemStall_i = stall; Op_i = op; Funct3_i = f3;
        RDaddr_i = rd; RS1addr_i = rs1; RS2addr_i = rs2; RegEqual_i = eq;
        if (!rst) begin ex_s = '0; mem_s = '0; wb_s = '0; end
        id  = '{op: op, f3: f3, rd: rd, rs1: rs1, rs2: rs2};
        haz = !stall && decode(ex_s).mr && ex_s.rd != 0 && (ex_s.rd == rs1 || ex_s.rd == rs2);
        e.pcw  = !rst || (!stall && !haz);
        e.ifw  = e.pcw;
        e.fl   = !stall && !haz && is_branch(id) && cond_met(id, eq);
        e.br   = decode(id).br;
        e.alu  = decode(ex_s).alu;
        e.src  = decode(ex_s).src;
        e.fa   = fwd(ex_s.rs1);
        e.fb   = fwd(ex_s.rs2);
        e.mr   = decode(mem_s).mr;
        e.mw   = decode(mem_s).mw;
        e.rw   = decode(wb_s).rw;
        e.m2r  = decode(wb_s).m2r;
        e.wbrd = wb_s.rd;
        if (!rst) begin
            nx_ex = '0; nx_mem = '0; nx_wb = '0;
        end else if (stall) begin
            nx_ex = ex_s; nx_mem = mem_s; nx_wb = wb_s;
        end else begin
            nx_ex = haz ? '0 : id; nx_mem = ex_s; nx_wb = mem_s;
        end
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("PCWrite",    8'(PCWrite_o),   8'(e.pcw));
                chk("IFIDWrite",  8'(IFIDWrite_o), 8'(e.ifw));
                chk("flush",      8'(flush_o),     8'(e.fl));
                chk("Branch",     8'(Branch_o),    8'(e.br));
                chk("ALUOp",      8'(ALUOp_o),     8'(e.alu));
                chk("ALUSrc",     8'(ALUSrc_o),    8'(e.src));
                chk("ForwardA",   8'(ForwardA_o),  8'(e.fa));
                chk("ForwardB",   8'(ForwardB_o),  8'(e.fb));
                chk("MemRead",    8'(MemRead_o),   8'(e.mr));
                chk("MemWrite",   8'(MemWrite_o),  8'(e.mw));
                chk("RegWrite",   8'(RegWrite_o),  8'(e.rw));
                chk("MemToReg",   8'(MemToReg_o),  8'(e.m2r));
                chk("WBRDaddr",   8'(WBRDaddr_o),  8'(e.wbrd));
            end
        end
    end

    initial begin
        logic [6:0] ops [7];
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW; ops[3] = OP_SW;
        ops[4] = OP_BR; ops[5] = 7'd0; ops[6] = 7'd0;

        step(0, 0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 0);
        step(0, 0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 0);
        // load-use on x5, then lw to x0 (no stall)
        step(1, 0, OP_LW, 3'd0, 5'd5, 5'd1, 5'd0, 0);
        step(1, 0, OP_R,  3'd0, 5'd6, 5'd5, 5'd2, 0);
        step(1, 0, OP_R,  3'd0, 5'd6, 5'd5, 5'd2, 0);
        step(1, 0, 7'd0,  3'd0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, OP_LW, 3'd0, 5'd0, 5'd1, 5'd0, 0);
        step(1, 0, OP_R,  3'd0, 5'd8, 5'd0, 5'd0, 0);
        // beq behind a load: stall first, flush next cycle; then not-taken beq
        step(1, 0, OP_LW, 3'd0, 5'd7, 5'd1, 5'd0, 0);
        step(1, 0, OP_BR, 3'd0, 5'd0, 5'd7, 5'd1, 1);
        step(1, 0, OP_BR, 3'd0, 5'd0, 5'd7, 5'd1, 1);
        step(1, 0, OP_BR, 3'd0, 5'd0, 5'd1, 5'd2, 0);
        // forwarding: two producers of x3, then a consumer of x3
        step(1, 0, OP_R,  3'd0, 5'd3, 5'd1, 5'd2, 0);
        step(1, 0, OP_R,  3'd0, 5'd3, 5'd1, 5'd2, 0);
        step(1, 0, OP_R,  3'd0, 5'd4, 5'd3, 5'd3, 0);
        step(1, 0, 7'd0,  3'd0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 7'd0,  3'd0, 5'd0, 5'd0, 5'd0, 0);
        // data-memory freeze around a store, then a hazard under stall
        step(1, 0, OP_SW, 3'd0, 5'd0, 5'd1, 5'd2, 0);
        step(1, 0, OP_LW, 3'd0, 5'd9, 5'd1, 5'd0, 0);
        step(1, 1, OP_R,  3'd0, 5'd2, 5'd9, 5'd0, 0);
        step(1, 1, OP_R,  3'd0, 5'd2, 5'd9, 5'd0, 0);
        step(1, 1, OP_R,  3'd0, 5'd2, 5'd9, 5'd0, 0);
        step(1, 0, OP_R,  3'd0, 5'd2, 5'd9, 5'd0, 0);
        step(1, 0, OP_R,  3'd0, 5'd2, 5'd9, 5'd0, 0);
        // bne-style funct3 with unequal operands
        step(1, 0, OP_BR, 3'd1, 5'd0, 5'd1, 5'd2, 0);
        // reset during a stall, then lw right after release
        step(1, 0, OP_SW, 3'd0, 5'd0, 5'd1, 5'd2, 0);
        step(1, 1, OP_R,  3'd0, 5'd1, 5'd1, 5'd2, 0);
        step(0, 1, OP_R,  3'd0, 5'd1, 5'd1, 5'd2, 0);
        step(1, 0, OP_LW, 3'd0, 5'd4, 5'd1, 5'd0, 0);
        step(1, 0, 7'd0,  3'd0, 5'd0, 5'd0, 5'd0, 0);
        step(1, 0, 7'd0,  3'd0, 5'd0, 5'd0, 5'd0, 0);

        for (int n = 0; n < 2000; n++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 6) == 0) op = 7'($urandom);
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 6) == 0), op,
                 3'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drain", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control and hazard unit for the 5-stage RISC-V core. It decodes the ID-stage opcode into EX, MEM and WB control bundles and carries them through internal ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards, resolves branches in ID, generates EX-stage forwarding selects, and freezes the pipeline on a data-memory stall.

## Interface
Parameters:
- REG_AW, 5: register-address width.
- OP_W, 7: opcode width.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- Op_i  in  OP_W  ID-stage opcode.
- Funct3_i  in  3  ID-stage funct3.
- RS1addr_i, RS2addr_i, RDaddr_i  in  REG_AW each  ID-stage register fields.
- RegEqual_i  in  1  ID-stage rs1 == rs2 comparison.
- MemStall_i  in  1  data memory busy; freezes the pipeline.
- PCWrite_o, IFIDWrite_o  out  1 each  PC and IF/ID register enables.
- flush_o  out  1  IF/ID flush (taken branch).
- Branch_o  out  1  ID instruction is a branch.
- ALUOp_o  out  2  EX-stage ALU op class.
- ALUSrc_o  out  1  EX-stage immediate select.
- ForwardA_o, ForwardB_o  out  2 each  EX operand selects: 00 reg, 10 EX/MEM, 01 MEM/WB.
- MemRead_o, MemWrite_o  out  1 each  MEM-stage controls.
- RegWrite_o, MemToReg_o  out  1 each  WB-stage controls.
- WBRDaddr_o  out  REG_AW  WB-stage destination register.

## Operation
- Decode (combinational, ID stage):
  - R-type 0110011: ALUOp 10, RegWrite 1.
  - addi 0010011: ALUOp 00, ALUSrc 1, RegWrite 1.
  - lw 0000011: ALUSrc 1, MemRead 1, RegWrite 1, MemToReg 1.
  - sw 0100011: ALUSrc 1, MemWrite 1.
  - branch 1100011: ALUOp 01, Branch 1.
  - Any other opcode, including 0000000: all controls 0 (NOP).
- Every output control defaults to 0; no latch inference.
- Pipeline: the ID/EX, EX/MEM and MEM/WB control registers each hold the control bundle, RD address, and (ID/EX only) RS1/RS2 addresses. Each stage outputs come from its own register.
- Load-use hazard: a load-use hazard exists when ID/EX.MemRead = 1, ID/EX.RD != 0, and ID/EX.RD equals RS1addr_i or RS2addr_i. Response:
  - PCWrite_o = 0 and IFIDWrite_o = 0.
  - A bubble (all-zero bundle) is written into ID/EX.
  - flush_o = 0.
- Branch taken when Branch = 1, the condition is met, and there is no load-use hazard: flush_o = 1 and PCWrite_o = 1. The branch instruction itself proceeds into ID/EX.
- Forwarding for ID/EX.RS1 (ForwardA_o) and RS2 (ForwardB_o), first match wins:
  - 10 if EX/MEM.RegWrite = 1, EX/MEM.RD != 0, and EX/MEM.RD matches.
  - 01 if MEM/WB.RegWrite = 1, MEM/WB.RD != 0, and MEM/WB.RD matches.
  - 00 otherwise.
- MemStall_i = 1 freezes the pipeline:
  - All three control registers hold their values.
  - PCWrite_o = 0, IFIDWrite_o = 0, flush_o = 0.
  - Hazard and branch evaluation is suppressed.
- Priority, highest first: MemStall_i, then load-use hazard, then branch flush.

## Timing
- Decode to ALUOp_o/ALUSrc_o: 1 cycle (ID/EX).
- Decode to MemRead_o/MemWrite_o: 2 cycles.
- Decode to RegWrite_o/MemToReg_o/WBRDaddr_o: 3 cycles.
- PCWrite_o, IFIDWrite_o, flush_o and Branch_o are combinational in the same cycle.
- ForwardA_o/ForwardB_o are combinational from the registered state.
- Reset (rst_i = 0, asynchronous): all pipeline registers clear to 0, so every registered output and both forward selects read 0 immediately. PCWrite_o and IFIDWrite_o read 1 during reset.
- Reset asserted mid-stall discards the in-flight controls; the first edge after release loads the current ID decode.
- A load-use stall lasts exactly 1 cycle unless MemStall_i extends it; the hazard is re-evaluated every cycle.
- Hazard and MemStall_i in the same cycle: MemStall_i wins and no bubble is inserted. The hazard is re-evaluated after MemStall_i drops.

## Configuration
- CTRL_BNE_EN defined: for opcode 1100011, Funct3_i 000 is beq (taken when RegEqual_i = 1) and 001 is bne (taken when RegEqual_i = 0). Any other funct3 decodes as a NOP with Branch 0.
- CTRL_BNE_EN undefined: Funct3_i is ignored and every 1100011 instruction is beq.

## Test plan
- Reset: assert rst_i = 0 mid-run -> all registered outputs and Forward selects read 0 immediately, PCWrite_o = 1; after release, lw (Op 0000011) in ID -> MemRead_o = 1 two edges later.
- Load-use: lw x5 in EX, add with RS1 = 5 in ID -> PCWrite_o = 0, IFIDWrite_o = 0 for 1 cycle; next cycle ALUOp_o = 00 (bubble); the add reaches EX one cycle later; a lw to x0 causes no stall.
- Branch: beq with RegEqual_i = 1 -> flush_o = 1 in the same cycle; with RegEqual_i = 0 -> flush_o = 0; beq on a load-use hazard -> flush_o = 0, stall first, flush the next cycle.
- Forwarding: add x3, then add x3 in EX/MEM and MEM/WB simultaneously with RS1 = 3 in EX -> ForwardA_o = 10; with only a MEM/WB match -> 01; with RD = 0 -> 00.
- MemStall: MemStall_i = 1 for 3 cycles during a sw sequence -> MemWrite_o held constant, PCWrite_o = 0, no bubble; the pipeline resumes unchanged.
- CTRL_BNE_EN build: Funct3_i = 001, RegEqual_i = 0 -> flush_o = 1; without the macro -> flush_o = 0.
